// File: rtl/definitions.sv
// Shared constants and types for the fetch stage and the downstream decoder/ALU.
// Holds the opcode set, the HALT encoding, the fetch FSM states and the branch-target table.
package definitions;

    localparam int kPcW     = 10;
    localparam int kInstrW  = 9;
    localparam int kLutIdxW = 4;
    localparam int kCntW    = 16;

    // Opcodes are 3 bits in the instruction; only [2:0] is compared.
    localparam logic [3:0] kJ   = 4'b0110;
    localparam logic [3:0] kBRE = 4'b0100;

    localparam logic [kInstrW-1:0] kHALT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef logic [2**kLutIdxW-1:0][kPcW-1:0] branch_lut_t;

    // Default table: entry i points at address 16*i.
    function automatic branch_lut_t init_branch_lut();
        branch_lut_t lut;
        for (int i = 0; i < 2**kLutIdxW; i++) begin
            lut[i] = kPcW'(16 * i);
        end
        return lut;
    endfunction

    localparam branch_lut_t kBranchLut = init_branch_lut();

endpackage

// File: rtl/fetch_unit_lut_target.sv
// Combinational branch-target ROM: maps a LUT index from the instruction to a fetch address.
module lut_target
    import definitions::*;
#(
    parameter int PC_W      = kPcW,
    parameter int LUT_IDX_W = kLutIdxW
) (
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [PC_W-1:0]      o_target
);

    assign o_target = PC_W'(kBranchLut[i_idx]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, J/BRE predecode with LUT redirect,
// start/halt/done sequencing and a saturating retired-instruction counter.
module fetch_unit
    import definitions::*;
#(
    parameter int                  PC_W      = kPcW,
    parameter int                  INSTR_W   = kInstrW,
    parameter int                  LUT_IDX_W = kLutIdxW,
    parameter int                  CNT_W     = kCntW,
    parameter logic [INSTR_W-1:0]  HALT_ENC  = kHALT
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               BranchFlag,
    input  logic               Stall,
    output logic [PC_W-1:0]    InstAddr,
    output logic               Valid,
    output logic               Done,
    output logic [CNT_W-1:0]   InstrCount
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    w_target;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;
    logic               w_valid;
    logic               w_start_acc;
    logic               w_is_halt;
    logic               w_take;
    logic [2:0]         w_opcode;

    assign w_opcode  = InstrIn[INSTR_W-1 -: 3];
    assign w_is_halt = (InstrIn == HALT_ENC);
    assign w_take    = (w_opcode == kJ[2:0]) ||
                       ((w_opcode == kBRE[2:0]) && BranchFlag);

    lut_target #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_lut_target (
        .i_idx    (InstrIn[LUT_IDX_W-1:0]),
        .o_target (w_target)
    );

    // InstrIn is only consulted in RUN, so garbage on the bus while idle is harmless.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid     = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = StartAddr;
                    w_start_acc = 1'b1;
                end
            end
            RUN: begin
                // Stall outranks HALT, which outranks the opcode decode (0x1FF is also opcode 111).
                if (!Stall) begin
                    if (w_is_halt) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_valid  = 1'b1;
                        w_pc_nxt = w_take ? w_target : r_pc + PC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= (w_state_nxt == DONE);
            if (w_start_acc) begin
                r_count <= '0;
            end else if (w_valid && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign InstAddr   = r_pc;
    assign Valid      = w_valid & ~Reset;
    assign Done       = r_done;
    assign InstrCount = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, J/BRE redirect, stall, halt/restart, wrap,
// counter saturation and asynchronous reset.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP      = 9'b000_00_0000;
    localparam logic [INSTR_W-1:0] HALT     = 9'h1FF;
    localparam logic [INSTR_W-1:0] J_IDX3   = 9'b110_00_0011;
    localparam logic [INSTR_W-1:0] J_IDX1   = 9'b110_00_0001;
    localparam logic [INSTR_W-1:0] BRE_IDX2 = 9'b100_00_0010;

    logic               CLK;
    logic               Reset;
    logic               Start;
    logic [PC_W-1:0]    StartAddr;
    logic [INSTR_W-1:0] InstrIn;
    logic               BranchFlag;
    logic               Stall;
    logic [PC_W-1:0]    InstAddr;
    logic               Valid;
    logic               Done;
    logic [CNT_W-1:0]   InstrCount;

    int checks;
    int errors;

    fetch_unit dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .InstrIn    (InstrIn),
        .BranchFlag (BranchFlag),
        .Stall      (Stall),
        .InstAddr   (InstAddr),
        .Valid      (Valid),
        .Done       (Done),
        .InstrCount (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [PC_W-1:0] addr);
        Start     = 1'b1;
        StartAddr = addr;
        tick();
        Start     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; InstrIn = NOP;
        BranchFlag = 1'b0; Stall = 1'b0;
        #3;
        checks++; if (InstAddr !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", InstAddr); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (InstrCount !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", InstrCount); end
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Valid); end
        tick(); tick();
        Reset = 1'b0;
        InstrIn = 'x;
        tick(); tick();
        checks++; if (InstAddr !== 10'd0) begin errors++; $display("FAIL idle_x_pc got %0d want 0", InstAddr); end
        checks++; if (Valid !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL idle_x_flags got valid=%b done=%b want 0 0", Valid, Done); end
    endtask

    task automatic test_start_seq();
        InstrIn = NOP;
        do_start(10'd5);
        for (int i = 0; i < 3; i++) begin
            checks++; if (InstAddr !== 10'(5 + i)) begin errors++; $display("FAIL seq_pc[%0d] got %0d want %0d", i, InstAddr, 5 + i); end
            checks++; if (InstrCount !== 16'(i)) begin errors++; $display("FAIL seq_cnt[%0d] got %0d want %0d", i, InstrCount, i); end
            checks++; if (Valid !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL seq_flags[%0d] got valid=%b done=%b want 1 0", i, Valid, Done); end
            if (i < 2) tick();
        end
    endtask

    task automatic test_jump();
        InstrIn = J_IDX3;
        #1;
        checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL jump_valid got %b want 1", Valid); end
        tick();
        checks++; if (InstAddr !== 10'd48) begin errors++; $display("FAIL jump_pc got %0d want 48", InstAddr); end
        checks++; if (InstrCount !== 16'd3) begin errors++; $display("FAIL jump_cnt got %0d want 3", InstrCount); end
    endtask

    task automatic test_branch();
        InstrIn = HALT;
        tick();
        checks++; if (Done !== 1'b1 || InstAddr !== 10'd48) begin errors++; $display("FAIL halt48 got done=%b pc=%0d want 1 48", Done, InstAddr); end
        do_start(10'd20);
        checks++; if (Done !== 1'b0 || InstrCount !== 16'd0) begin errors++; $display("FAIL restart20 got done=%b cnt=%0d want 0 0", Done, InstrCount); end
        InstrIn = BRE_IDX2; BranchFlag = 1'b1;
        tick();
        checks++; if (InstAddr !== 10'd32) begin errors++; $display("FAIL bre_taken_pc got %0d want 32", InstAddr); end
        InstrIn = HALT;
        tick();
        do_start(10'd20);
        InstrIn = BRE_IDX2; BranchFlag = 1'b0;
        #1;
        checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL bre_nt_valid got %b want 1", Valid); end
        tick();
        checks++; if (InstAddr !== 10'd21) begin errors++; $display("FAIL bre_nt_pc got %0d want 21", InstAddr); end
        checks++; if (InstrCount !== 16'd1) begin errors++; $display("FAIL bre_nt_cnt got %0d want 1", InstrCount); end
    endtask

    task automatic test_stall();
        InstrIn = J_IDX1; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b want 0", i, Valid); end
            tick();
            checks++; if (InstAddr !== 10'd21 || InstrCount !== 16'd1) begin errors++; $display("FAIL stall_hold[%0d] got pc=%0d cnt=%0d want 21 1", i, InstAddr, InstrCount); end
        end
        Stall = 1'b0;
        tick();
        checks++; if (InstAddr !== 10'd16 || InstrCount !== 16'd2) begin errors++; $display("FAIL stall_release got pc=%0d cnt=%0d want 16 2", InstAddr, InstrCount); end
        InstrIn = HALT; Stall = 1'b1;
        tick();
        checks++; if (Done !== 1'b0 || InstAddr !== 10'd16) begin errors++; $display("FAIL stall_over_halt got done=%b pc=%0d want 0 16", Done, InstAddr); end
        Stall = 1'b0;
    endtask

    task automatic test_halt_restart();
        InstrIn = HALT;
        tick();
        InstrIn = NOP;
        do_start(10'd39);
        tick();
        InstrIn = HALT;
        #1;
        checks++; if (InstAddr !== 10'd40 || Valid !== 1'b0) begin errors++; $display("FAIL halt_present got pc=%0d valid=%b want 40 0", InstAddr, Valid); end
        tick();
        checks++; if (Done !== 1'b1 || InstAddr !== 10'd40) begin errors++; $display("FAIL halt_done got done=%b pc=%0d want 1 40", Done, InstAddr); end
        InstrIn = 'x;
        tick();
        checks++; if (Done !== 1'b1 || InstAddr !== 10'd40 || Valid !== 1'b0) begin errors++; $display("FAIL done_hold got done=%b pc=%0d valid=%b want 1 40 0", Done, InstAddr, Valid); end
        InstrIn = NOP;
        do_start(10'd0);
        checks++; if (InstAddr !== 10'd0 || InstrCount !== 16'd0 || Done !== 1'b0) begin errors++; $display("FAIL restart0 got pc=%0d cnt=%0d done=%b want 0 0 0", InstAddr, InstrCount, Done); end
    endtask

    task automatic test_start_ignored();
        InstrIn = NOP; Start = 1'b1; StartAddr = 10'd500;
        tick();
        Start = 1'b0;
        checks++; if (InstAddr !== 10'd1 || InstrCount !== 16'd1) begin errors++; $display("FAIL start_in_run got pc=%0d cnt=%0d want 1 1", InstAddr, InstrCount); end
    endtask

    task automatic test_wrap();
        InstrIn = HALT;
        tick();
        InstrIn = NOP;
        do_start(10'd1023);
        tick();
        checks++; if (InstAddr !== 10'd0 || InstrCount !== 16'd1) begin errors++; $display("FAIL pc_wrap got pc=%0d cnt=%0d want 0 1", InstAddr, InstrCount); end
    endtask

    task automatic test_saturate();
        InstrIn = NOP;
        repeat (65534) tick();
        checks++; if (InstrCount !== 16'hFFFF) begin errors++; $display("FAIL cnt_full got %0d want 65535", InstrCount); end
        tick(); tick();
        checks++; if (InstrCount !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %0d want 65535", InstrCount); end
    endtask

    task automatic test_async_reset();
        InstrIn = NOP;
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (InstAddr !== 10'd0 || Done !== 1'b0 || InstrCount !== 16'd0) begin errors++; $display("FAIL async_reset got pc=%0d done=%b cnt=%0d want 0 0 0", InstAddr, Done, InstrCount); end
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", Valid); end
        Start = 1'b1; StartAddr = 10'd77;
        tick(); tick();
        checks++; if (InstAddr !== 10'd0 || Done !== 1'b0 || InstrCount !== 16'd0 || Valid !== 1'b0) begin errors++; $display("FAIL reset_held got pc=%0d done=%b cnt=%0d valid=%b want 0 0 0 0", InstAddr, Done, InstrCount, Valid); end
        Start = 1'b0;
        Reset = 1'b0;
        #1;
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got valid=%b want 0", Valid); end
        do_start(10'd3);
        checks++; if (InstAddr !== 10'd3 || Valid !== 1'b1) begin errors++; $display("FAIL post_reset_start got pc=%0d valid=%b want 3 1", InstAddr, Valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start_seq();
        test_jump();
        test_branch();
        test_stall();
        test_halt_restart();
        test_start_ignored();
        test_wrap();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
